cim_share_arbiter: RTL
======================

// Module: cim_share_arbiter
// PURPOSE
//  Shares one CIM crossbar tile array between num_requesters layer function units (conv/FC func blocks).
//  Grants round-robin, muxes the granted unit's write port (we/addr/data) onto the crossbar, fires compute,
//  waits for the crossbar to finish, then hands back a done pulse. Sits between the func units and the CIM array.
// PARAMETERS
//  num_requesters   4     number of func units sharing the crossbar (>=2)
//  xbar_size        256   crossbar rows; address width = $clog2(xbar_size)
//  datatype_size    8     width of one written element
//  max_hold_cycles  1024  watchdog limit in s_arb_grant (used only with CIM_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                        clock, all logic on posedge
//  rst          in   1                        synchronous reset, active-high
//  i_req        in   num_requesters           request per unit, level
//  i_done       in   num_requesters           1-cycle pulse: granted unit finished writing
//  i_cim_we     in   [num_requesters]x1       per-unit write enable
//  i_cim_addr   in   [num_requesters]xAW      per-unit write address
//  i_cim_data   in   [num_requesters]xDW      per-unit write data
//  o_grant      out  num_requesters           one-hot grant, 0 when none
//  o_grant_id   out  $clog2(num_requesters)   index of granted unit
//  o_cim_we     out  1                        muxed write enable
//  o_cim_addr   out  AW                       muxed address
//  o_cim_data   out  DW                       muxed data
//  o_cim_start  out  1                        1-cycle compute start to crossbar
//  i_cim_busy   in   1                        crossbar computing
//  o_done       out  num_requesters           1-cycle pulse to unit whose compute finished
//  o_timeout    out  1                        1-cycle pulse on watchdog release (0 when macro off)
// BEHAVIOUR
//  Reset: every output 0, state s_arb_reset, rr pointer = 0, watchdog = 0; rst mid-operation aborts at once, no o_done.
//  States (t_cim_arb_state): s_arb_reset -> s_arb_idle next cycle unconditionally.
//  s_arb_idle: if any i_req, pick first requester at/after rr pointer (wrapping), register grant -> s_arb_grant.
//   Grant visible on o_grant/o_grant_id the cycle after the pick (1-cycle arbitration latency).
//  s_arb_grant: o_cim_we/addr/data = combinational mux of granted unit's inputs; all others ignored.
//   Grant held even if i_req drops. i_done from granted unit -> s_arb_start; i_done from non-granted units ignored.
//  s_arb_start: o_grant held, o_cim_we forced 0, o_cim_start=1 for exactly one cycle -> s_arb_wait_busy.
//  s_arb_wait_busy: when i_cim_busy=1 -> s_arb_wait_done (busy already high on entry counts).
//  s_arb_wait_done: when i_cim_busy=0 -> o_done[grant]=1 one cycle, rr pointer = grant_id+1 (wraps to 0),
//   o_grant cleared, -> s_arb_idle. Minimum gap between grants: 1 idle cycle.
//  Outside s_arb_grant, o_cim_we/addr/data are 0.
//  Fairness: unit that just finished has lowest priority next pick; N simultaneous reqs each served within N grants.
//  Illegal state encoding -> s_arb_reset.
// CONFIGURATION
//  CIM_ARB_TIMEOUT_EN defined: counter runs in s_arb_grant; on reaching max_hold_cycles without i_done,
//   o_timeout=1 one cycle, no compute, no o_done, rr pointer advances, -> s_arb_idle. i_done on the
//   limit cycle wins over timeout.
//  Undefined: no counter, o_timeout tied 0, grant held indefinitely until i_done.
// STRUCTURE
//  cim_arb_pkg: t_cim_arb_state enum, localparam widths helper, function rr_first_set(req, ptr).
//  Sub-module rr_priority_picker (comb): inputs req vector + pointer, outputs valid + index. Rest in top.
// TESTING
//  1 single req: i_req=4'b0100 -> o_grant=4'b0100 next cycle, id=2; writes addr 5 data 8'hA3 appear on o_cim_*.
//  2 all req=4'b1111 from reset -> grant order 0,1,2,3,0; each o_done precedes next grant.
//  3 i_done -> o_cim_start single pulse; busy high 10 cycles -> o_done[id] exactly 1 cycle after busy falls.
//  4 rst asserted in s_arb_wait_done -> all outputs 0 next cycle, no o_done, rr pointer 0.
//  5 CIM_ARB_TIMEOUT_EN, max_hold_cycles=8, no i_done -> o_timeout after 8 grant cycles, next unit granted.
//  6 i_done from non-granted unit and req drop during grant -> ignored, grant unchanged.

Source files
------------

// File: rtl/cim_share_arbiter_pkg.sv
// Shared types and helpers for the CIM crossbar share arbiter.
// Holds the FSM state enum and the round-robin first-set search.
package cim_arb_pkg;

    typedef enum logic [2:0] {
        s_arb_reset     = 3'd0,
        s_arb_idle      = 3'd1,
        s_arb_grant     = 3'd2,
        s_arb_start     = 3'd3,
        s_arb_wait_busy = 3'd4,
        s_arb_wait_done = 3'd5
    } t_cim_arb_state;

    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned MAX_IDXW = 5;

    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit at or after ptr, wrapping at n; ptr must be below n.
    function automatic int unsigned rr_first_set(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        n,
        input int unsigned        ptr
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (!found && k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_IDXW-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cim_share_arbiter_picker.sv
// Combinational round-robin picker: first requester at/after the pointer.
// Valid whenever any request is present.
module rr_priority_picker
    import cim_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        valid_o        = |req_i;
        idx_o          = PW'(rr_first_set(req_ext, N, 32'(ptr_i)));
    end

endmodule

// File: rtl/cim_share_arbiter.sv
// Round-robin sharing of one CIM crossbar between several func units.
// Optional grant watchdog enabled by defining CIM_ARB_TIMEOUT_EN.
module cim_share_arbiter
    import cim_arb_pkg::*;
#(
    parameter int num_requesters  = 4,
    parameter int xbar_size       = 256,
    parameter int datatype_size   = 8,
    parameter int max_hold_cycles = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [num_requesters-1:0]                 i_req,
    input  logic [num_requesters-1:0]                 i_done,
    input  logic [num_requesters-1:0]                 i_cim_we,
    input  logic [num_requesters*$clog2(xbar_size)-1:0] i_cim_addr,
    input  logic [num_requesters*datatype_size-1:0]   i_cim_data,
    output logic [num_requesters-1:0]                 o_grant,
    output logic [$clog2(num_requesters)-1:0]         o_grant_id,
    output logic                                      o_cim_we,
    output logic [$clog2(xbar_size)-1:0]              o_cim_addr,
    output logic [datatype_size-1:0]                  o_cim_data,
    output logic                                      o_cim_start,
    input  logic                                      i_cim_busy,
    output logic [num_requesters-1:0]                 o_done,
    output logic                                      o_timeout
);

    localparam int IW = $clog2(num_requesters);
    localparam int AW = $clog2(xbar_size);
    localparam int DW = datatype_size;

    t_cim_arb_state            state_q;
    logic [num_requesters-1:0] grant_q;
    logic [IW-1:0]             gid_q;
    logic [IW-1:0]             ptr_q;
    logic [IW-1:0]             ptr_d;
    logic                      start_q;
    logic [num_requesters-1:0] done_q;
    logic                      pick_valid;
    logic [IW-1:0]             pick_idx;
    logic                      done_sel;

    rr_priority_picker #(
        .N  (num_requesters),
        .PW (IW)
    ) u_picker (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // grant_q is one-hot, so this only sees the granted unit's i_done
    assign done_sel = |(i_done & grant_q);
    assign ptr_d = (gid_q == IW'(num_requesters - 1)) ? '0 : gid_q + 1'b1;

`ifdef CIM_ARB_TIMEOUT_EN
    localparam int WDW = clog2w(max_hold_cycles);
    localparam logic [WDW-1:0] WD_LAST = WDW'(max_hold_cycles - 1);
    logic [WDW-1:0] wd_q;
    logic           timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= s_arb_reset;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef CIM_ARB_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef CIM_ARB_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
            case (state_q)
                s_arb_reset: state_q <= s_arb_idle;
                s_arb_idle: begin
                    if (pick_valid) begin
                        grant_q <= num_requesters'(1) << pick_idx;
                        gid_q   <= pick_idx;
                        state_q <= s_arb_grant;
                    end
                end
                s_arb_grant: begin
                    if (done_sel) begin
                        start_q <= 1'b1;
                        state_q <= s_arb_start;
                    end
`ifdef CIM_ARB_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        gid_q     <= '0;
                        ptr_q     <= ptr_d;
                        state_q   <= s_arb_idle;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                s_arb_start: state_q <= s_arb_wait_busy;
                s_arb_wait_busy: begin
                    if (i_cim_busy) state_q <= s_arb_wait_done;
                end
                s_arb_wait_done: begin
                    if (!i_cim_busy) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        gid_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= s_arb_idle;
                    end
                end
                default: begin
                    grant_q <= '0;
                    gid_q   <= '0;
                    state_q <= s_arb_reset;
                end
            endcase
        end
    end

    always_comb begin
        o_cim_we   = 1'b0;
        o_cim_addr = '0;
        o_cim_data = '0;
        if (state_q == s_arb_grant) begin
            for (int u = 0; u < num_requesters; u++) begin
                if (grant_q[u]) begin
                    o_cim_we   = i_cim_we[u];
                    o_cim_addr = i_cim_addr[u*AW +: AW];
                    o_cim_data = i_cim_data[u*DW +: DW];
                end
            end
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_id  = gid_q;
    assign o_cim_start = start_q;
    assign o_done      = done_q;

endmodule
